// File: rtl/pmod_led_arbiter.sv
// pmod_led_arbiter: round-robin time-slice sharing of an active-low 8-bit PMOD LED bank.
// Optional idle heartbeat on PMOD_D[0] when PMOD_LED_ARB_HEARTBEAT_EN is defined.
module pmod_led_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TICK_CYCLES = 12_000,
  parameter int SLOT_TICKS  = 500,
  parameter int HB_TICKS    = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   pattern,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [7:0]           PMOD_D
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int SW = $clog2(SLOT_TICKS + 1);
  typedef enum logic {IDLE, OWN} state_t;
  if (N_REQ < 2 || N_REQ > 8 || TICK_CYCLES < 2 || SLOT_TICKS < 1 || HB_TICKS < 1) begin : g_bad
    $error("pmod_led_arbiter: parameter out of range");
  end
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, sel;
  logic [SW-1:0] slot_q, slot_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0] pmod_q, pmod_d, idle_pmod;
  logic tick, rel;
  assign tick = presc_q == PW'(TICK_CYCLES - 1);
  assign rel = !req[owner_q] || (slot_q == SW'(SLOT_TICKS) && |(req & ~grant_q));
  // lowest k wins, so the first requester at or above ptr is chosen
  always_comb begin
    sel = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % N_REQ]) sel = IW'((int'(ptr_q) + k) % N_REQ);
  end
`ifdef PMOD_LED_ARB_HEARTBEAT_EN
  localparam int HW = $clog2(HB_TICKS + 1);
  logic [HW-1:0] hb_q, hb_d;
  logic hb_led_q, hb_led_d, hb_wrap, hb_hold;
  always_comb begin
    hb_hold = state_q == OWN || state_d == OWN;
    hb_wrap = tick && hb_q == HW'(HB_TICKS - 1);
    hb_d = hb_hold || hb_wrap ? '0 : tick ? hb_q + 1'b1 : hb_q;
    hb_led_d = hb_hold ? 1'b0 : hb_wrap ? ~hb_led_q : hb_led_q;
    idle_pmod = {7'h7F, ~hb_led_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_q <= '0;
      hb_led_q <= 1'b0;
    end else begin
      hb_q <= hb_d;
      hb_led_q <= hb_led_d;
    end
  end
`else
  assign idle_pmod = 8'hFF;
`endif
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    slot_d = slot_q;
    grant_d = grant_q;
    pmod_d = pmod_q;
    if (state_q == IDLE) begin
      pmod_d = idle_pmod;
      if (|req) begin
        state_d = OWN;
        owner_d = sel;
        grant_d = N_REQ'(1) << sel;
        slot_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      pmod_d = 8'hFF;
      ptr_d = owner_q == IW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
    end else begin
      pmod_d = ~pattern[8*owner_q +: 8];
      slot_d = tick && slot_q != SW'(SLOT_TICKS) ? slot_q + 1'b1 : slot_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      slot_q <= '0;
      grant_q <= '0;
      pmod_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      slot_q <= slot_d;
      grant_q <= grant_d;
      pmod_q <= pmod_d;
    end
  end
  assign grant = grant_q;
  assign busy = |grant_q;
  assign PMOD_D = pmod_q;
endmodule

// File: tb/tb_pmod_led_arbiter.sv
// tb_pmod_led_arbiter: directed checks of the PMOD LED arbiter (N_REQ=4, TICK_CYCLES=4, SLOT_TICKS=2).
module tb_pmod_led_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] pattern = '0;
  logic [3:0] grant;
  logic busy;
  logic [7:0] PMOD_D;
  int n_cmp = 0, n_err = 0;
  pmod_led_arbiter #(.N_REQ(4), .TICK_CYCLES(4), .SLOT_TICKS(2), .HB_TICKS(2)) dut (
    .clk(clk), .rst(rst), .req(req), .pattern(pattern),
    .grant(grant), .busy(busy), .PMOD_D(PMOD_D)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int owners[$];
    int hold, gap, n_fe, n_ff;
    logic [3:0] prev;
    cyc(3);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pmod", PMOD_D, 8'hFF);
    req = 4'b1111;
    cyc(2);
    chk("rst_hold_grant", grant, 0);
    chk("rst_hold_pmod", PMOD_D, 8'hFF);
    rst = 1'b0;
    req = '0;
    cyc(1);
    req = 4'b0100;
    pattern[23:16] = 8'h05;
    cyc(1);
    chk("single_grant", grant, 4'b0100);
    chk("single_busy", busy, 1);
    chk("single_pmod_lag", PMOD_D, 8'hFF);
    cyc(1);
    chk("single_pmod", PMOD_D, 8'hFA);
    req = '0;
    cyc(1);
    chk("single_rel_grant", grant, 0);
    chk("single_rel_busy", busy, 0);
    chk("single_rel_pmod", PMOD_D, 8'hFF);
    n_fe = 0;
    n_ff = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (PMOD_D == 8'hFE) n_fe++;
      else if (PMOD_D == 8'hFF) n_ff++;
    end
`ifdef PMOD_LED_ARB_HEARTBEAT_EN
    chk("hb_toggle", n_fe > 0 && n_ff > 0 && n_fe + n_ff == 24, 1);
`else
    chk("idle_const", n_ff, 24);
`endif
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 4'b1111;
    prev = '0;
    hold = 0;
    gap = 0;
    for (int c = 0; c < 200 && owners.size() < 5; c++) begin
      cyc(1);
      chk("rr_busy", busy, |grant);
      chk("rr_onehot", $countones(grant) <= 1, 1);
      if (grant != 0) begin
        if (prev == 0) begin
          owners.push_back(int'(grant));
          if (owners.size() > 1) chk("rr_gap", gap, 1);
          hold = 0;
        end
        hold++;
      end else begin
        if (prev != 0) begin
          chk("rr_hold", hold >= 6 && hold <= 9, 1);
          gap = 0;
        end
        gap++;
      end
      prev = grant;
    end
    chk("rr_count", owners.size(), 5);
    for (int i = 0; i < owners.size(); i++) chk("rr_order", owners[i], 1 << (i % 4));
    req = '0;
    cyc(2);
    chk("rr_drain", grant, 0);
    req = 4'b0010;
    cyc(1);
    chk("alone_grant", grant, 4'b0010);
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      chk("alone_hold", grant, 4'b0010);
    end
    req = 4'b1010;
    cyc(1);
    chk("preempt_gap", grant, 0);
    cyc(1);
    chk("preempt_grant", grant, 4'b1000);
    req = '0;
    cyc(2);
    req = 4'b0010;
    cyc(1);
    chk("mid_first", grant, 4'b0010);
    req = '0;
    cyc(1);
    req = 4'b0010;
    pattern[15:8] = 8'h3C;
    cyc(1);
    chk("mid_owner", grant, 4'b0010);
    cyc(1);
    chk("mid_pmod", PMOD_D, 8'hC3);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pmod", PMOD_D, 8'hFF);
    rst = 1'b0;
    req = 4'b1111;
    cyc(1);
    chk("mid_rst_ptr", grant, 4'b0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
